mem_lsu: RTL and testbench

MEM-stage load/store unit: the data-bus initiator that consumes the MEM-stage control and data signals and turns each load or store into one request/grant/valid transaction on the data memory port. It stalls the pipeline for the duration of the transaction. It returns sign- or zero-extended load data to write-back. It sits directly after the EXE/MEM pipeline register and drives the core's data bus (OBI-style: req/gnt, then rvalid).

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : MEM-stage load/store unit. Turns each load or store into a
//                single req/gnt/rvalid data-bus transaction, stalls the
//                pipeline while it is in flight and returns formatted
//                (sign/zero-extended) load data to write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_mem_mem2reg,
    input  logic        i_mem_wmem,
    input  logic        i_mem_lsb,
    input  logic        i_mem_lsh,
    input  logic        i_mem_loadsignext,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_access;
    logic [1:0]  w_size;
    logic        w_misaligned;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signext;
    logic        r_is_load;

    logic [31:0] w_shifted;
    logic [31:0] w_load_fmt;

    assign w_access = i_mem_mem2reg | i_mem_wmem;

    // Decode access size (byte beats halfword beats word) and alignment
    always_comb begin
        w_size = c_SZ_WORD;
        if (i_mem_lsb)
            w_size = c_SZ_BYTE;
        else if (i_mem_lsh)
            w_size = c_SZ_HALF;

        w_misaligned = 1'b0;
        if (w_size == c_SZ_HALF)
            w_misaligned = i_mem_addr[0];
        else if (w_size == c_SZ_WORD)
            w_misaligned = (i_mem_addr[1:0] != 2'b00);
    end

    // Byte enables and lane-replicated write data for the presented access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_mem_wdata;
        case (w_size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << i_mem_addr[1:0];
                w_wdata = {4{i_mem_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_mem_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_mem_wdata;
            end
        endcase
    end

    assign w_start      = (r_state == S_IDLE) & w_access & ~w_misaligned;
    assign o_misaligned = (r_state == S_IDLE) & w_access &  w_misaligned;
    assign o_stall      = w_start | (r_state == S_REQ) | (r_state == S_WAIT);

    // Align the returned word to the addressed lane and extend it
    always_comb begin
        w_shifted  = data_rdata_i >> {r_off, 3'b000};
        w_load_fmt = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load_fmt = {{24{r_signext & w_shifted[7]}},  w_shifted[7:0]};
            c_SZ_HALF: w_load_fmt = {{16{r_signext & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_fmt = w_shifted;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: one transaction at a time, DONE always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)       w_state_next = S_REQ;
            S_REQ:   if (data_gnt_i)    w_state_next = S_WAIT;
            S_WAIT:  if (data_rvalid_i) w_state_next = S_DONE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Registered bus outputs and transaction latches, captured when leaving IDLE
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            data_req_o   <= 1'b0;
            data_addr_o  <= 32'd0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'd0;
            data_wdata_o <= 32'd0;
            r_size       <= c_SZ_WORD;
            r_off        <= 2'd0;
            r_signext    <= 1'b0;
            r_is_load    <= 1'b0;
        end else begin
            data_req_o <= (w_state_next == S_REQ);
            if (w_start) begin
                data_addr_o  <= {i_mem_addr[31:2], 2'b00};
                data_we_o    <= i_mem_wmem;
                data_be_o    <= w_be;
                data_wdata_o <= w_wdata;
                r_size       <= w_size;
                r_off        <= i_mem_addr[1:0];
                r_signext    <= i_mem_loadsignext;
                r_is_load    <= ~i_mem_wmem;
            end
        end
    end

    // Load result capture on rvalid in WAIT; valid pulse lines up with DONE
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_load_data  <= 32'd0;
            o_load_valid <= 1'b0;
        end else begin
            o_load_valid <= (r_state == S_WAIT) & data_rvalid_i & r_is_load;
            if ((r_state == S_WAIT) && data_rvalid_i && r_is_load)
                o_load_data <= w_load_fmt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu; directed and randomized
//                loads/stores against a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_resetn;
    logic        i_mem_mem2reg, i_mem_wmem, i_mem_lsb, i_mem_lsh, i_mem_loadsignext;
    logic [31:0] i_mem_addr, i_mem_wdata;
    logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        o_stall, o_load_valid, o_misaligned;
    logic [31:0] o_load_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_load;

    always #5 i_clk = ~i_clk;

    mem_lsu dut (
        .i_clk(i_clk), .i_resetn(i_resetn),
        .i_mem_mem2reg(i_mem_mem2reg), .i_mem_wmem(i_mem_wmem),
        .i_mem_lsb(i_mem_lsb), .i_mem_lsh(i_mem_lsh),
        .i_mem_loadsignext(i_mem_loadsignext),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .o_stall(o_stall), .o_load_data(o_load_data),
        .o_load_valid(o_load_valid), .o_misaligned(o_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_mem_mem2reg = 0; i_mem_wmem = 0; i_mem_lsb = 0; i_mem_lsh = 0;
        i_mem_loadsignext = 0; i_mem_addr = 0; i_mem_wdata = 0;
    endtask

    // Idle cycle with optional stray gnt/rvalid which must be ignored
    task automatic idle_cycle(input bit stray);
        drive_idle();
        data_gnt_i    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        data_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        data_rdata_i  = $urandom;
        #3;
        check("idle_stall", 32'(o_stall), 0);
        check("idle_req",   32'(data_req_o), 0);
        check("idle_lv",    32'(o_load_valid), 0);
        @(posedge i_clk); #1;
        data_gnt_i = 0; data_rvalid_i = 0;
    endtask

    // One instruction from presentation to retire; called at posedge+1.
    // gd = cycles of gnt delay, vd = cycles of rvalid delay.
    task automatic run_op(input bit ld, input bit st, input bit lsb, input bit lsh,
                          input bit sx, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int vd, input bit stray);
        int          a, size; // size in bytes
        bit          is_load, mis;
        logic [31:0] ebe, ewd, r, eld;
        a       = int'(addr % 4);
        size    = lsb ? 1 : (lsh ? 2 : 4);
        is_load = !st;
        mis     = (size == 2 && (a % 2) == 1) || (size == 4 && a != 0);
        if (size == 1) begin
            ebe = 32'(1 << a);
            ewd = (wd & 32'hFF) * 32'h01010101;
        end else if (size == 2) begin
            ebe = (a >= 2) ? 32'hC : 32'h3;
            ewd = (wd & 32'hFFFF) * 32'h00010001;
        end else begin
            ebe = 32'hF;
            ewd = wd;
        end
        r = rd >> (8 * a);
        if (size == 1) begin
            eld = r & 32'hFF;
            if (sx && eld >= 128) eld = eld - 256;
        end else if (size == 2) begin
            eld = r & 32'hFFFF;
            if (sx && eld >= 32768) eld = eld - 65536;
        end else begin
            eld = r;
        end

        i_mem_mem2reg = ld; i_mem_wmem = st; i_mem_lsb = lsb; i_mem_lsh = lsh;
        i_mem_loadsignext = sx; i_mem_addr = addr; i_mem_wdata = wd;
        data_gnt_i = 0;
        data_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        #3;
        check("p_stall", 32'(o_stall), 32'(!mis));
        check("p_mis",   32'(o_misaligned), 32'(mis));
        check("p_req",   32'(data_req_o), 0);
        @(posedge i_clk); #1;
        data_rvalid_i = 0;
        if (mis) begin
            drive_idle();
            return;
        end
        // request phase
        for (int i = 0; i <= gd; i++) begin
            data_gnt_i    = (i == gd);
            data_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            #3;
            check("r_req",   32'(data_req_o), 1);
            check("r_stall", 32'(o_stall), 1);
            check("r_addr",  data_addr_o, addr & 32'hFFFF_FFFC);
            check("r_we",    32'(data_we_o), 32'(st));
            check("r_be",    32'(data_be_o), ebe);
            if (st) check("r_wdata", data_wdata_o, ewd);
            @(posedge i_clk); #1;
        end
        // response phase
        for (int i = 0; i <= vd; i++) begin
            data_gnt_i    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            data_rvalid_i = (i == vd);
            data_rdata_i  = (i == vd) ? rd : $urandom;
            #3;
            check("w_req",   32'(data_req_o), 0);
            check("w_stall", 32'(o_stall), 1);
            check("w_lv",    32'(o_load_valid), 0);
            @(posedge i_clk); #1;
        end
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = $urandom;
        if (is_load) last_load = eld;
        #3;
        check("d_stall", 32'(o_stall), 0);
        check("d_req",   32'(data_req_o), 0);
        check("d_lv",    32'(o_load_valid), 32'(is_load));
        check("d_data",  o_load_data, last_load);
        @(posedge i_clk); #1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
        last_load = 0;
        i_resetn = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_req",   32'(data_req_o), 0);
        check("rst_addr",  data_addr_o, 0);
        check("rst_be",    32'(data_be_o), 0);
        check("rst_wdata", data_wdata_o, 0);
        check("rst_ld",    o_load_data, 0);
        check("rst_lv",    32'(o_load_valid), 0);
        check("rst_stall", 32'(o_stall), 0);
        i_resetn = 1;
        @(posedge i_clk); #1;

        // directed cases
        run_op(1, 0, 0, 0, 0, 32'h0000_1004, 0, 32'hDEADBEEF, 0, 0, 0);
        run_op(1, 0, 1, 0, 1, 32'h0000_2003, 0, 32'h80112233, 0, 0, 0);
        run_op(1, 0, 1, 0, 0, 32'h0000_2003, 0, 32'h80112233, 0, 0, 0);
        run_op(0, 1, 0, 1, 0, 32'h0000_3002, 32'h0000ABCD, 0, 3, 0, 0);
        run_op(1, 0, 0, 0, 0, 32'h0000_4002, 0, 0, 0, 0, 0);
        run_op(1, 0, 0, 1, 1, 32'h0000_4001, 0, 0, 0, 0, 0);
        idle_cycle(0);
        idle_cycle(1);
        run_op(1, 0, 0, 1, 1, 32'h0000_5002, 0, 32'h8001_7FFF, 1, 5, 1);
        run_op(1, 1, 0, 0, 0, 32'h0000_6000, 32'h1234_5678, 0, 0, 2, 1);

        // reset in the middle of a request
        i_mem_mem2reg = 1; i_mem_addr = 32'h0000_7000;
        #3;
        check("pre_rst_stall", 32'(o_stall), 1);
        @(posedge i_clk); #1;
        #2;
        check("pre_rst_req", 32'(data_req_o), 1);
        drive_idle();
        i_resetn = 0;
        last_load = 0;
        #1;
        check("arst_req",  32'(data_req_o), 0);
        check("arst_addr", data_addr_o, 0);
        check("arst_be",   32'(data_be_o), 0);
        check("arst_ld",   o_load_data, 0);
        check("arst_stall", 32'(o_stall), 0);
        @(posedge i_clk); #3;
        i_resetn = 1;
        @(posedge i_clk); #1;
        idle_cycle(1);
        idle_cycle(1);
        run_op(1, 0, 0, 0, 0, 32'h0000_8008, 0, 32'hCAFE_F00D, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle_cycle(1);
            run_op(op != 1, op == 1 || op == 2,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
